// File: rtl/if_fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage, the decode stage and the
// hazard-unit bench: datapath width, reset PC, bubble encoding and FSM states.
package if_fetch_stage_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013; // addi x0,x0,0

    // S_FETCH: request on the bus; S_HOLD: fetched word parked while stalled;
    // S_DROP: request on the bus whose data belongs to a redirected-away path.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DROP  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: PC, instruction and valid bit with load,
// flush-to-bubble and hold. Flush wins over load; a flush keeps the PC.
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter int               XLEN      = if_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0]  NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] instr_in,
    output logic [XLEN-1:0] if_id_pc,
    output logic [XLEN-1:0] if_id_instr,
    output logic            if_id_valid
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            valid_q, valid_d;

    // Next-value selection: hold by default, bubble on flush, capture on load.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load) begin
            pc_d    = pc_in;
            instr_d = instr_in;
            valid_d = 1'b1;
        end
    end

    // Register update; reset leaves a bubble at PC zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign if_id_pc    = pc_q;
    assign if_id_instr = instr_q;
    assign if_id_valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives a valid/ready instruction-memory
// request with variable latency, honours hazard-unit stalls and ID redirects,
// and feeds the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int               XLEN      = if_fetch_stage_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = if_fetch_stage_pkg::RESET_PC,
    parameter logic [XLEN-1:0]  NOP_INSTR = if_fetch_stage_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCWrite,
    input  logic            IF_ID_Write,
    input  logic            Branch_taken,
    input  logic [XLEN-1:0] Branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] IF_ID_PC,
    output logic [XLEN-1:0] IF_ID_Instr,
    output logic            IF_ID_Valid,
    output logic            fetch_busy
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [XLEN-1:0] hold_buf_q, hold_buf_d;

    logic            advance;
    logic            ifid_load;
    logic            ifid_flush;
    logic [XLEN-1:0] ifid_pc_in;
    logic [XLEN-1:0] ifid_instr_in;

    // A stall from either hazard control freezes the front end.
    assign advance = PCWrite & IF_ID_Write;

    // The request address is a register so it stays stable until accepted.
    assign imem_req   = ~rst & ((state_q == S_FETCH) | (state_q == S_DROP));
    assign imem_addr  = req_addr_q;
    assign fetch_busy = imem_req;

    // Next-state, PC and IF/ID control; a redirect outranks stalls and returns.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        hold_buf_d    = hold_buf_q;
        ifid_load     = 1'b0;
        ifid_flush    = 1'b0;
        ifid_pc_in    = req_addr_q;
        ifid_instr_in = imem_rdata;

        if (Branch_taken) begin
            ifid_flush = 1'b1;
            pc_d       = Branch_target;
        end

        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    if (Branch_taken) begin
                        req_addr_d = Branch_target;
                    end else if (advance) begin
                        ifid_load  = 1'b1;
                        pc_d       = req_addr_q + XLEN'(4);
                        req_addr_d = req_addr_q + XLEN'(4);
                    end else begin
                        hold_buf_d = imem_rdata;
                        state_d    = S_HOLD;
                    end
                end else begin
                    if (Branch_taken) begin
                        // Address must stay on the bus; the return is discarded.
                        state_d = S_DROP;
                    end else if (advance) begin
                        ifid_flush = 1'b1;
                    end
                end
            end

            S_HOLD: begin
                if (Branch_taken) begin
                    req_addr_d = Branch_target;
                    state_d    = S_FETCH;
                end else if (advance) begin
                    ifid_load     = 1'b1;
                    ifid_instr_in = hold_buf_q;
                    pc_d          = req_addr_q + XLEN'(4);
                    req_addr_d    = req_addr_q + XLEN'(4);
                    state_d       = S_FETCH;
                end
            end

            S_DROP: begin
                if (advance) begin
                    ifid_flush = 1'b1;
                end
                if (imem_ready) begin
                    // Restart at the live PC, including a redirect arriving now.
                    req_addr_d = Branch_taken ? Branch_target : pc_q;
                    state_d    = S_FETCH;
                end
            end

            default: begin
                req_addr_d = pc_q;
                state_d    = S_FETCH;
            end
        endcase
    end

    // State, PC, request address and hold buffer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            hold_buf_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            hold_buf_q <= hold_buf_d;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (ifid_load),
        .flush       (ifid_flush),
        .pc_in       (ifid_pc_in),
        .instr_in    (ifid_instr_in),
        .if_id_pc    (IF_ID_PC),
        .if_id_instr (IF_ID_Instr),
        .if_id_valid (IF_ID_Valid)
    );

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a fetch-stream model.
module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_PC;
    logic [31:0] IF_ID_Instr;
    logic        IF_ID_Valid;
    logic        fetch_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: program-order next PC, address on the bus, whether a
    // request is outstanding, whether that request is stale, parked word.
    bit          m_init = 0;
    logic [31:0] m_next_pc;
    logic [31:0] m_addr;
    bit          m_out;
    bit          m_stale;
    bit          m_buf_v;
    logic [31:0] m_buf;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .PCWrite       (PCWrite),
        .IF_ID_Write   (IF_ID_Write),
        .Branch_taken  (Branch_taken),
        .Branch_target (Branch_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_PC      (IF_ID_PC),
        .IF_ID_Instr   (IF_ID_Instr),
        .IF_ID_Valid   (IF_ID_Valid),
        .fetch_busy    (fetch_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: each address holds a distinct scrambled word.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic bubble();
        m_instr = NOP;
        m_valid = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit          adv;
        bit          deliver;
        bit          have;
        logic [31:0] data;
        if (rst) begin
            m_init    = 1;
            m_next_pc = 32'h0;
            m_addr    = 32'h0;
            m_out     = 1;
            m_stale   = 0;
            m_buf_v   = 0;
            m_buf     = 32'h0;
            m_pc      = 32'h0;
            m_instr   = NOP;
            m_valid   = 0;
        end else if (m_init) begin
            adv     = PCWrite & IF_ID_Write;
            deliver = m_out & imem_ready;
            if (Branch_taken) begin
                bubble();
                m_next_pc = Branch_target;
                m_buf_v   = 0;
                if (m_out && !deliver) begin
                    m_stale = 1;
                end else begin
                    m_addr  = Branch_target;
                    m_out   = 1;
                    m_stale = 0;
                end
            end else if (m_stale) begin
                if (deliver) begin
                    m_stale = 0;
                    m_addr  = m_next_pc;
                end
                if (adv) bubble();
            end else begin
                have = m_buf_v || deliver;
                data = m_buf_v ? m_buf : imem_rdata;
                if (have && adv) begin
                    m_pc      = m_next_pc;
                    m_instr   = data;
                    m_valid   = 1;
                    m_next_pc = m_next_pc + 32'd4;
                    m_addr    = m_next_pc;
                    m_out     = 1;
                    m_buf_v   = 0;
                end else if (have) begin
                    m_buf_v = 1;
                    m_buf   = data;
                    m_out   = 0;
                end else if (adv) begin
                    bubble();
                end
            end
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, step the model.
    task automatic cycle(input bit r, input bit pcw, input bit ifw, input bit bt,
                         input logic [31:0] tgt, input bit rdy);
        rst           = r;
        PCWrite       = pcw;
        IF_ID_Write   = ifw;
        Branch_taken  = bt;
        Branch_target = tgt;
        imem_ready    = rdy;
        imem_rdata    = rdy ? mem_f(m_addr) : $urandom;
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (m_init) begin
                chk("imem_req", {31'b0, imem_req}, {31'b0, (!rst && m_out)});
                chk("fetch_busy", {31'b0, fetch_busy}, {31'b0, (!rst && m_out)});
                if (!rst && m_out) chk("imem_addr", imem_addr, m_addr);
                chk("if_id_valid", {31'b0, IF_ID_Valid}, {31'b0, m_valid});
                chk("if_id_instr", IF_ID_Instr, m_instr);
                if (m_valid) chk("if_id_pc", IF_ID_PC, m_pc);
            end
        end
    end

    initial begin
        rst = 1; PCWrite = 0; IF_ID_Write = 0; Branch_taken = 0;
        Branch_target = 0; imem_ready = 0; imem_rdata = 0;

        // Reset values
        cycle(1, 0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("rst_pc", IF_ID_PC, 32'h0);
        chk("rst_instr", IF_ID_Instr, 32'h13);
        chk("rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("rst_req", {31'b0, imem_req}, 32'h0);

        // Zero-wait memory, no stalls: one instruction per cycle
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 1, 0, 0, 1);
            chk("zw_pc", IF_ID_PC, 32'(i * 4));
            chk("zw_valid", {31'b0, IF_ID_Valid}, 32'h1);
            chk("zw_instr", IF_ID_Instr, mem_f(32'(i * 4)));
        end
        chk("zw_addr", imem_addr, 32'h10);

        // Three-cycle latency on the fetch of 0x4
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 1, 0, 0, 1);
        chk("lat_first_pc", IF_ID_PC, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 0, 0, 0);
            chk("lat_addr", imem_addr, 32'h4);
            chk("lat_valid", {31'b0, IF_ID_Valid}, 32'h0);
            chk("lat_instr", IF_ID_Instr, 32'h13);
        end
        cycle(0, 1, 1, 0, 0, 1);
        chk("lat_pc", IF_ID_PC, 32'h4);
        chk("lat_ld_instr", IF_ID_Instr, mem_f(32'h4));
        chk("lat_next_addr", imem_addr, 32'h8);

        // Stall coinciding with ready parks the word; release loads it
        cycle(0, 0, 0, 0, 0, 1);
        chk("hold_req", {31'b0, imem_req}, 32'h0);
        chk("hold_pc", IF_ID_PC, 32'h4);
        cycle(0, 0, 0, 0, 0, 1);
        chk("hold2_req", {31'b0, imem_req}, 32'h0);
        chk("hold2_pc", IF_ID_PC, 32'h4);
        cycle(0, 1, 1, 0, 0, 0);
        chk("rel_pc", IF_ID_PC, 32'h8);
        chk("rel_instr", IF_ID_Instr, mem_f(32'h8));
        chk("rel_addr", imem_addr, 32'hC);

        // Redirect while the fetch of 0xC is outstanding
        cycle(0, 1, 1, 1, 32'h100, 0);
        chk("drop_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("drop_addr", imem_addr, 32'hC);
        chk("drop_busy", {31'b0, fetch_busy}, 32'h1);
        cycle(0, 1, 1, 0, 0, 0);
        chk("drop_addr2", imem_addr, 32'hC);
        cycle(0, 1, 1, 0, 0, 1);
        chk("drop_done_addr", imem_addr, 32'h100);
        chk("drop_done_valid", {31'b0, IF_ID_Valid}, 32'h0);
        cycle(0, 1, 1, 0, 0, 1);
        chk("tgt_pc", IF_ID_PC, 32'h100);
        chk("tgt_valid", {31'b0, IF_ID_Valid}, 32'h1);

        // Redirect together with stall while parked
        cycle(0, 0, 0, 0, 0, 1);
        chk("hold_br_req", {31'b0, imem_req}, 32'h0);
        cycle(0, 0, 0, 1, 32'h200, 0);
        chk("hold_br_addr", imem_addr, 32'h200);
        chk("hold_br_valid", {31'b0, IF_ID_Valid}, 32'h0);
        cycle(0, 1, 1, 0, 0, 1);
        chk("hold_br_pc", IF_ID_PC, 32'h200);
        chk("hold_br_instr", IF_ID_Instr, mem_f(32'h200));

        // PC wrap, then reset in the middle of a request
        cycle(0, 1, 1, 1, 32'hFFFF_FFFC, 1);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cycle(0, 1, 1, 0, 0, 1);
        chk("wrap_pc", IF_ID_PC, 32'hFFFF_FFFC);
        chk("wrap_next", imem_addr, 32'h0);
        cycle(0, 1, 1, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0);
        chk("mid_rst_pc", IF_ID_PC, 32'h0);
        chk("mid_rst_instr", IF_ID_Instr, 32'h13);
        chk("mid_rst_valid", {31'b0, IF_ID_Valid}, 32'h0);
        chk("mid_rst_req", {31'b0, imem_req}, 32'h0);
        cycle(0, 1, 1, 0, 0, 0);
        chk("post_rst_req", {31'b0, imem_req}, 32'h1);
        chk("post_rst_addr", imem_addr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 499) == 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 4) != 0,
                  $urandom_range(0, 15) == 0,
                  $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 9) < 6);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register. It sits directly upstream of the hazard detection unit and consumes that unit's PCWrite / IF_ID_Write stall controls. It owns the PC, issues requests to instruction memory over a valid/ready handshake with variable latency, and applies branch redirects from ID by flushing IF/ID and discarding stale fetches. It supplies IF_ID_PC / IF_ID_Instr to decode, which extracts Rs1/Rs2 for hazard checks.

Parameters:
XLEN, 32, PC / instruction / address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) written into IF/ID on flush or empty fetch

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
PCWrite  in  1  from hazard unit; 0 = hold PC
IF_ID_Write  in  1  from hazard unit; 0 = hold IF/ID
Branch_taken  in  1  redirect request from ID stage
Branch_target  in  XLEN  redirect PC, valid when Branch_taken=1
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, stable while imem_req=1 and not accepted
imem_ready  in  1  memory returns imem_rdata this cycle; completes the request
imem_rdata  in  XLEN  fetched instruction, sampled when imem_req & imem_ready
IF_ID_PC  out  XLEN  PC of the instruction in IF/ID
IF_ID_Instr  out  XLEN  instruction in IF/ID
IF_ID_Valid  out  1  1 = real instruction; 0 = bubble
fetch_busy  out  1  1 while a request is outstanding (S_FETCH or S_DROP)

Behaviour:
- Reset is the only asynchronous-free init: the clk edge with rst=1 sets pc=RESET_PC, req_addr=RESET_PC, state=S_FETCH, IF_ID_PC=0, IF_ID_Instr=NOP_INSTR, IF_ID_Valid=0, and clears the hold buffer. imem_req=0 while rst=1.
- Define advance = PCWrite & IF_ID_Write. Either one low counts as a stall.
- Redirect = Branch_taken. Redirect has priority over stall and over fetch return.
- Redirect in any state:
  - IF/ID is loaded with Valid=0, Instr=NOP_INSTR, PC unchanged.
  - pc is set to Branch_target.
- req_addr is the register that drives imem_addr. It is reloaded from pc only when a new request starts.
- States:
  - S_FETCH: imem_req=1, imem_addr=req_addr.
    - ready & redirect: drop rdata; req_addr=pc=Branch_target; stay.
    - ready & advance: IF/ID={req_addr, rdata, 1}; pc=req_addr=req_addr+4; stay. This gives one instruction per cycle with zero-wait memory.
    - ready & stall: hold_buf=rdata; IF/ID unchanged; go to S_HOLD.
    - !ready & redirect: go to S_DROP. pc=Branch_target; req_addr holds, because the address must stay stable until accepted.
    - !ready & advance: IF/ID={x, NOP_INSTR, 0} (bubble).
    - !ready & stall: IF/ID holds.
  - S_HOLD: imem_req=0.
    - redirect: discard hold_buf; req_addr=pc=Branch_target; go to S_FETCH.
    - advance: IF/ID={req_addr, hold_buf, 1}; pc=req_addr=req_addr+4; go to S_FETCH.
    - stall: remain in S_HOLD; IF/ID holds.
  - S_DROP: imem_req=1, imem_addr=req_addr (the stale address).
    - On ready: discard rdata; req_addr=pc; go to S_FETCH.
    - IF/ID follows advance/stall with bubble fill.
    - A further redirect updates pc only.
- The PC increment is modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- No instruction is ever lost or duplicated across a stall. No instruction fetched before a redirect ever reaches IF/ID with Valid=1.
- rst mid-request: the state machine returns to S_FETCH at RESET_PC. The memory must abandon the request when rst=1 (system contract).

Decomposition:
- Shared package: XLEN, RESET_PC, NOP_INSTR, and the state enum {S_FETCH, S_HOLD, S_DROP}. These are shared with the decode stage and the hazard unit testbench.
- One natural sub-module: if_id_reg. It holds the PC/Instr/Valid register with load, flush-to-bubble and hold controls. The FSM and PC logic stay in the top module.

Test Plan:
- Zero-wait memory (imem_ready=1 always), no stalls, from reset -> IF_ID_PC = 0,4,8,12 on consecutive cycles; Valid=1 from the first edge after rst falls.
- Memory latency 3 cycles -> imem_addr is held at 0x4 for 3 cycles; IF/ID carries bubbles (Valid=0, Instr=0x13) meanwhile; the instruction at 0x4 loads on the ready edge.
- Hazard stall (PCWrite=IF_ID_Write=0 for 2 cycles) coinciding with imem_ready -> enters S_HOLD with imem_req=0; IF/ID is unchanged; on release, the held instruction loads with the correct PC and 0x(pc+4) is requested next.
- Branch_taken, target 0x100, while a request to 0x20 is outstanding -> S_DROP; the 0x20 data never appears with Valid=1; the next request is 0x100; IF/ID is flushed to NOP.
- Branch_taken asserted together with the stall inputs in S_HOLD -> redirect wins; the buffer is discarded; next fetch is at the target.
- pc=0xFFFF_FFFC, then rst asserted mid-latency -> after the wrap the next fetch is at 0x0; after reset pc=RESET_PC and all outputs are at their reset values.
